bypass_rf_wb_sched: RTL and testbench

Writeback scheduler for the bypassing register file. Shares the RF's two data-write ports among NREQ writeback requesters using round-robin arbitration. Sequences the pipeline's out-of-order free requests into the strictly in-order free-write port the RF requires. Sits between the pipeline writeback/commit stages and the RF's write-data and free-write ports.

---
 rtl/bypass_rf_wb_sched_pkg.sv | 15 +
 rtl/bypass_rf_wb_sched_rr_pick2.sv | 53 +++++
 rtl/bypass_rf_wb_sched.sv | 144 ++++++++++++++
 tb/tb_bypass_rf_wb_sched.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/bypass_rf_wb_sched_pkg.sv
// Shared definitions for the RF writeback scheduler: default widths,
// requester-count ceiling and free-sequencer state encoding.
package bypass_rf_wb_sched_pkg;
  localparam int NREQ_MAX   = 8;
  localparam int NAME_W_DEF = 1;
  localparam int DATA_W_DEF = 32;
  // Requester index width sized for the largest supported NREQ.
  localparam int REQ_IW     = $clog2(NREQ_MAX);

  typedef logic [NAME_W_DEF-1:0] name_t;
  typedef logic [DATA_W_DEF-1:0] data_t;

  localparam logic [0:0] SEQ_IDLE  = 1'b0;
  localparam logic [0:0] SEQ_OFFER = 1'b1;
endpackage

// File: rtl/bypass_rf_wb_sched_rr_pick2.sv
// Combinational two-winner circular priority picker. Winner 1 is the first
// set bit of valid scanning upward from ptr; winner 2 is the next set bit of
// valid2 (a subset of valid) in the same scan order, skipping winner 1.
module bypass_rf_wb_sched_rr_pick2 #(
  parameter int NREQ = 4,
  parameter int IW   = 3
) (
  input  logic [NREQ-1:0] valid,
  input  logic [NREQ-1:0] valid2,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant1,
  output logic [NREQ-1:0] grant2,
  output logic [IW-1:0]   idx1,
  output logic [IW-1:0]   idx2,
  output logic            v1,
  output logic            v2
);

  // First winner: earliest valid requester in circular order from ptr.
  always_comb begin
    int j;
    j      = 0;
    grant1 = '0;
    idx1   = '0;
    v1     = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!v1 && valid[j]) begin
        v1        = 1'b1;
        idx1      = IW'(j);
        grant1[j] = 1'b1;
      end
    end
  end

  // Second winner: kept in its own block so valid2 may depend on grant1.
  always_comb begin
    int j;
    j      = 0;
    grant2 = '0;
    idx2   = '0;
    v2     = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!v2 && valid2[j] && !grant1[j]) begin
        v2        = 1'b1;
        idx2      = IW'(j);
        grant2[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bypass_rf_wb_sched.sv
// Writeback scheduler: round-robin shares the RF's two write ports among
// NREQ requesters, and turns out-of-order frees into the RF's strictly
// in-order free-write stream, never offering a name before its write issued.
module bypass_rf_wb_sched
  import bypass_rf_wb_sched_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int name_width = 1,
  parameter int data_width = 32
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [NREQ-1:0]            REQ_VALID,
  input  logic [NREQ*name_width-1:0] REQ_NAME,
  input  logic [NREQ*data_width-1:0] REQ_DATA,
  output logic [NREQ-1:0]            REQ_READY,
  output logic [name_width-1:0]      NAME_IN_1,
  output logic [data_width-1:0]      D_IN_1,
  output logic                       WE_1,
  output logic [name_width-1:0]      NAME_IN_2,
  output logic [data_width-1:0]      D_IN_2,
  output logic                       WE_2,
  input  logic                       FREE_VALID,
  input  logic [name_width-1:0]      FREE_NAME,
  output logic [name_width-1:0]      W_F,
  output logic                       WFE,
  input  logic                       F_READY,
  output logic                       ERR
);

  localparam int NN = 2 ** name_width;

  logic [REQ_IW-1:0]     rr_ptr, idx1, idx2;
  logic [NREQ-1:0]       grant1, grant2, dup, valid2;
  logic                  v1, v2, dup_err;
  logic [name_width-1:0] name1;

  logic [NN-1:0]         pend_free, written, pend_n, written_n;
  logic [name_width-1:0] owner, owner_n;
  logic [0:0]            state, state_n;
  logic                  retire, dbl_free, go;

  // Requesters sharing the port-1 winner's name are barred from port 2.
  always_comb begin
    name1 = REQ_NAME[int'(idx1)*name_width +: name_width];
    dup   = '0;
    for (int j = 0; j < NREQ; j++)
      if (REQ_VALID[j] && !grant1[j] &&
          REQ_NAME[j*name_width +: name_width] == name1)
        dup[j] = 1'b1;
    valid2  = REQ_VALID & ~dup;
    dup_err = v1 && (|dup);
  end

  bypass_rf_wb_sched_rr_pick2 #(.NREQ(NREQ), .IW(REQ_IW)) u_pick (
    .valid  (REQ_VALID),
    .valid2 (valid2),
    .ptr    (rr_ptr),
    .grant1 (grant1),
    .grant2 (grant2),
    .idx1   (idx1),
    .idx2   (idx2),
    .v1     (v1),
    .v2     (v2)
  );

  assign REQ_READY = RST ? '0 : (grant1 | grant2);

  // Advance the round-robin pointer past the last granted requester.
  always_ff @(posedge CLK) begin
    if (RST)     rr_ptr <= '0;
    else if (v2) rr_ptr <= REQ_IW'((int'(idx2) + 1) % NREQ);
    else if (v1) rr_ptr <= REQ_IW'((int'(idx1) + 1) % NREQ);
  end

  // Register grants onto the RF write ports (1-cycle write latency).
  always_ff @(posedge CLK) begin
    if (RST) begin
      WE_1 <= 1'b0; NAME_IN_1 <= '0; D_IN_1 <= '0;
      WE_2 <= 1'b0; NAME_IN_2 <= '0; D_IN_2 <= '0;
    end else begin
      WE_1 <= v1;
      WE_2 <= v2;
      if (v1) begin
        NAME_IN_1 <= REQ_NAME[int'(idx1)*name_width +: name_width];
        D_IN_1    <= REQ_DATA[int'(idx1)*data_width +: data_width];
      end
      if (v2) begin
        NAME_IN_2 <= REQ_NAME[int'(idx2)*name_width +: name_width];
        D_IN_2    <= REQ_DATA[int'(idx2)*data_width +: data_width];
      end
    end
  end

  // Next-state bitmaps: retirement clears first, then new sets (set wins).
  // The next owner is checked against next-state bitmaps so retirements
  // can proceed back to back at one per cycle.
  always_comb begin
    retire    = WFE && F_READY;
    dbl_free  = FREE_VALID && pend_free[FREE_NAME];
    pend_n    = pend_free;
    written_n = written;
    if (retire) begin
      pend_n[owner]    = 1'b0;
      written_n[owner] = 1'b0;
    end
    if (FREE_VALID && !dbl_free) pend_n[FREE_NAME] = 1'b1;
    if (WE_1) written_n[NAME_IN_1] = 1'b1;
    if (WE_2) written_n[NAME_IN_2] = 1'b1;
    owner_n = retire ? owner + 1'b1 : owner;
    go      = pend_n[owner_n] && written_n[owner_n];
  end

  // Free sequencer: offer the in-order head once it is freed and written.
  always_comb begin
    state_n = state;
    case (state)
      SEQ_IDLE:  state_n = go ? SEQ_OFFER : SEQ_IDLE;
      SEQ_OFFER: state_n = (!F_READY || go) ? SEQ_OFFER : SEQ_IDLE;
      default:   state_n = SEQ_IDLE;
    endcase
  end

  // Sequencer state, bitmaps and sticky error.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= SEQ_IDLE;
      owner     <= '0;
      pend_free <= '0;
      written   <= '0;
      ERR       <= 1'b0;
    end else begin
      state     <= state_n;
      owner     <= owner_n;
      pend_free <= pend_n;
      written   <= written_n;
      if (dup_err || dbl_free) ERR <= 1'b1;
    end
  end

  assign WFE = (state == SEQ_OFFER);
  assign W_F = owner;

endmodule

// File: tb/tb_bypass_rf_wb_sched.sv
// Directed bench for the writeback scheduler: arbitration, port timing,
// in-order free sequencing, stalls, error flag and reset.
module tb_bypass_rf_wb_sched;
  localparam int NREQ = 4;
  localparam int NW   = 1;
  localparam int DW   = 32;

  logic                 CLK = 1'b0;
  logic                 RST;
  logic [NREQ-1:0]      REQ_VALID;
  logic [NREQ*NW-1:0]   REQ_NAME;
  logic [NREQ*DW-1:0]   REQ_DATA;
  logic [NREQ-1:0]      REQ_READY;
  logic [NW-1:0]        NAME_IN_1, NAME_IN_2, W_F, FREE_NAME;
  logic [DW-1:0]        D_IN_1, D_IN_2;
  logic                 WE_1, WE_2, WFE, FREE_VALID, F_READY, ERR;

  int checks = 0;
  int errors = 0;

  bypass_rf_wb_sched #(.NREQ(NREQ), .name_width(NW), .data_width(DW)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_NAME(REQ_NAME), .REQ_DATA(REQ_DATA),
    .REQ_READY(REQ_READY),
    .NAME_IN_1(NAME_IN_1), .D_IN_1(D_IN_1), .WE_1(WE_1),
    .NAME_IN_2(NAME_IN_2), .D_IN_2(D_IN_2), .WE_2(WE_2),
    .FREE_VALID(FREE_VALID), .FREE_NAME(FREE_NAME),
    .W_F(W_F), .WFE(WFE), .F_READY(F_READY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic n, input logic [31:0] d);
    REQ_NAME[i*NW +: NW] = n;
    REQ_DATA[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    REQ_VALID = '0; FREE_VALID = 1'b0; FREE_NAME = '0; F_READY = 1'b1;
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  initial begin
    REQ_NAME = '0; REQ_DATA = '0;
    // Reset state; REQ_READY held low while RST even with requests up.
    do_reset();
    RST = 1'b1; REQ_VALID = 4'b1111;
    #1 chk("rst_ready", REQ_READY, 0);
    tick();
    chk("rst_we1", WE_1, 0); chk("rst_we2", WE_2, 0);
    chk("rst_wfe", WFE, 0);  chk("rst_wf", W_F, 0);
    chk("rst_err", ERR, 0);  chk("rst_d1", D_IN_1, 0);
    RST = 1'b0;

    // Single write.
    do_reset();
    set_req(0, 1'b1, 32'hA5); REQ_VALID = 4'b0001;
    #1 chk("single_ready", REQ_READY, 4'b0001);
    tick(); REQ_VALID = '0;
    chk("single_we1", WE_1, 1); chk("single_name1", NAME_IN_1, 1);
    chk("single_d1", D_IN_1, 32'hA5); chk("single_we2", WE_2, 0);

    // Contention: all four valid for two cycles, then pointer wrapped to 0.
    do_reset();
    set_req(0, 1'b0, 32'h11); set_req(1, 1'b1, 32'h22);
    set_req(2, 1'b0, 32'h33); set_req(3, 1'b1, 32'h44);
    REQ_VALID = 4'b1111;
    #1 chk("cont_c1_ready", REQ_READY, 4'b0011);
    tick();
    chk("cont_c1_d1", D_IN_1, 32'h11); chk("cont_c1_d2", D_IN_2, 32'h22);
    chk("cont_c1_we2", WE_2, 1);
    chk("cont_c2_ready", REQ_READY, 4'b1100);
    tick();
    chk("cont_c2_d1", D_IN_1, 32'h33); chk("cont_c2_d2", D_IN_2, 32'h44);
    chk("cont_c3_ready", REQ_READY, 4'b0011);
    REQ_VALID = '0;

    // Out-of-order free: names 0,1 written; free 1 then 0.
    do_reset();
    set_req(0, 1'b0, 32'h100); set_req(1, 1'b1, 32'h101);
    REQ_VALID = 4'b0011;
    tick();
    REQ_VALID = '0;
    FREE_VALID = 1'b1; FREE_NAME = 1'b1;
    tick();
    chk("ooo_wfe_wait", WFE, 0);
    FREE_NAME = 1'b0;
    tick();
    FREE_VALID = 1'b0;
    chk("ooo_wfe0", WFE, 1); chk("ooo_wf0", W_F, 0);
    tick();
    chk("ooo_wfe1", WFE, 1); chk("ooo_wf1", W_F, 1);
    tick();
    chk("ooo_done", WFE, 0); chk("ooo_owner_wrap", W_F, 0);
    chk("ooo_err", ERR, 0);

    // Free before write: no offer until the write has gone out.
    do_reset();
    FREE_VALID = 1'b1; FREE_NAME = 1'b0;
    tick();
    FREE_VALID = 1'b0;
    chk("fbw_wfe_a", WFE, 0);
    tick();
    chk("fbw_wfe_b", WFE, 0);
    set_req(0, 1'b0, 32'h55); REQ_VALID = 4'b0001;
    tick();
    REQ_VALID = '0;
    chk("fbw_we1_T", WE_1, 1); chk("fbw_wfe_T", WFE, 0);
    tick();
    chk("fbw_wfe_T1", WFE, 1); chk("fbw_wf_T1", W_F, 0);
    tick();
    chk("fbw_retired", WFE, 0);

    // F_READY stall: offer held three cycles, retires on first ready.
    do_reset();
    F_READY = 1'b0;
    set_req(0, 1'b0, 32'h77); REQ_VALID = 4'b0001;
    tick();
    REQ_VALID = '0;
    FREE_VALID = 1'b1; FREE_NAME = 1'b0;
    tick();
    FREE_VALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stall_wfe%0d", i), WFE, 1);
      chk($sformatf("stall_wf%0d", i), W_F, 0);
      tick();
    end
    F_READY = 1'b1;
    chk("stall_wfe_last", WFE, 1);
    tick();
    chk("stall_retired", WFE, 0); chk("stall_owner", W_F, 1);

    // Duplicate name on requesters 0 and 2.
    do_reset();
    set_req(0, 1'b1, 32'hD0); set_req(2, 1'b1, 32'hD2);
    REQ_VALID = 4'b0101;
    #1 chk("dup_ready", REQ_READY, 4'b0001);
    tick();
    REQ_VALID = '0;
    chk("dup_err", ERR, 1); chk("dup_we2", WE_2, 0); chk("dup_d1", D_IN_1, 32'hD0);

    // Double free, then reset mid-stream clears everything.
    do_reset();
    FREE_VALID = 1'b1; FREE_NAME = 1'b1;
    tick();
    chk("dbl_first_err", ERR, 0);
    tick();
    FREE_VALID = 1'b0;
    chk("dbl_err", ERR, 1);
    set_req(0, 1'b0, 32'hE0); set_req(1, 1'b1, 32'hE1);
    REQ_VALID = 4'b0011;
    tick();
    chk("mid_we1_pre", WE_1, 1);
    RST = 1'b1;
    #1 chk("mid_ready", REQ_READY, 0);
    tick();
    chk("mid_we1", WE_1, 0); chk("mid_we2", WE_2, 0);
    chk("mid_wfe", WFE, 0);  chk("mid_wf", W_F, 0);
    chk("mid_err", ERR, 0);  chk("mid_d2", D_IN_2, 0);
    chk("mid_name2", NAME_IN_2, 0);
    RST = 1'b0; REQ_VALID = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
